ula: RTL and testbench
======================

// Module: ula
// PURPOSE
//  6-bit combinational-datapath ALU with registered outputs; selects logic or arithmetic
//  operation via modo/op_sel and reports result, carry/borrow and zero flags.
//  Standalone execution unit for small 6-bit datapaths; one result per clock.
// PARAMETERS
//  none (width fixed at 6 bits)
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  A          in   6  operand A (unsigned / two's complement as op requires)
//  B          in   6  operand B
//  modo       in   1  1 = logic mode, 0 = arithmetic mode
//  op_sel     in   3  operation select within mode
//  O          out  6  registered result
//  carry_out  out  1  registered carry/borrow/shifted-out bit
//  zero       out  1  registered flag, 1 when O == 6'b000000
// BEHAVIOUR
//  - One clock; reset synchronous active-high, priority over all operations.
//  - Reset values: O=6'b000000, carry_out=0, zero=1.
//  - Latency 1 cycle: inputs sampled at rising edge N, O/carry_out/zero valid after edge N.
//    No handshake; new operation accepted every cycle; outputs hold between edges.
//  - Logic mode (modo=1), carry_out=0 always:
//    000 A&B | 001 A|B | 010 A^B | 011 ~A | 100 ~(A&B) | 101 ~(A|B) | 110 ~(A^B) | 111 A
//  - Arithmetic mode (modo=0), 7-bit internal, O = low 6 bits:
//    000 A+B, carry_out = bit 6 of sum
//    001 A-B, carry_out = 1 on borrow (A < B unsigned)
//    010 A+1, carry_out = 1 when A=6'h3F (wraps to 0)
//    011 A-1, carry_out = 1 when A=0 (wraps to 6'h3F)
//    100 B-A, carry_out = 1 on borrow (B < A unsigned)
//    101 -A (two's complement), carry_out = 1 when A != 0
//    110 A<<1, LSB filled 0, carry_out = A[5]
//    111 A>>1 logical, MSB filled 0, carry_out = A[0]
//  - zero computed from the new O value in the same cycle (consistent with O).
//  - Switching modo/op_sel mid-stream: next edge reflects new selection; no history kept.
//  - Reset asserted with valid inputs: reset wins; deassert -> next edge computes normally.
//  - No X propagation on outputs: all op_sel codes defined in both modes.
// TESTING
//  1 reset=1 one edge -> O=000000, carry_out=0, zero=1; reset=0 holds until next op edge.
//  2 modo=1,A=000000,B=111111: op 000 -> O=000000,zero=1; 001 -> 111111,zero=0; 010 -> 111111.
//  3 modo=1,op 011,A=111111 -> O=000000,zero=1,carry_out=0; op 111 A=101010 -> O=101010.
//  4 modo=0,op 000,A=111111,B=000001 -> O=000000,carry_out=1,zero=1; A=3,B=4 -> O=000111,c=0.
//  5 modo=0,op 001,A=000101,B=000111 -> O=111110,carry_out=1; A=7,B=5 -> O=000010,c=0.
//  6 modo=0,op 110,A=100001 -> O=000010,c=1; op 111,A=000011 -> O=000001,c=1; reset mid-run -> reset values.

Source files
------------

// File: rtl/ula.sv
// 6-bit ALU with registered result, carry/borrow and zero flags.
// Operands and selects are sampled on each rising edge; results appear after that edge.
// Operands are treated as unsigned for carry/borrow. A 7-bit internal result carries
// the carry/borrow/shifted-out bit in bit 6.
module ula (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] A,
  input  logic [5:0] B,
  input  logic       modo,
  input  logic [2:0] op_sel,
  output logic [5:0] O,
  output logic       carry_out,
  output logic       zero
);

  // Logic-mode operation codes (modo = 1)
  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpXor  = 3'b010;
  localparam logic [2:0] OpNotA = 3'b011;
  localparam logic [2:0] OpNand = 3'b100;
  localparam logic [2:0] OpNor  = 3'b101;
  localparam logic [2:0] OpXnor = 3'b110;
  localparam logic [2:0] OpPass = 3'b111;

  // Arithmetic-mode operation codes (modo = 0)
  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpInc = 3'b010;
  localparam logic [2:0] OpDec = 3'b011;
  localparam logic [2:0] OpRsb = 3'b100;
  localparam logic [2:0] OpNeg = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpShr = 3'b111;

  logic [6:0] a_ext;
  logic [6:0] b_ext;
  logic [5:0] logic_res;
  logic [6:0] arith_res;
  logic [5:0] o_d, o_q;
  logic       carry_d, carry_q;
  logic       zero_d, zero_q;

  assign a_ext = {1'b0, A};
  assign b_ext = {1'b0, B};

  // Bitwise operations; these never produce a carry
  always_comb begin
    logic_res = '0;
    case (op_sel)
      OpAnd:   logic_res = A & B;
      OpOr:    logic_res = A | B;
      OpXor:   logic_res = A ^ B;
      OpNotA:  logic_res = ~A;
      OpNand:  logic_res = ~(A & B);
      OpNor:   logic_res = ~(A | B);
      OpXnor:  logic_res = ~(A ^ B);
      OpPass:  logic_res = A;
      default: logic_res = '0;
    endcase
  end

  // Arithmetic operations; bit 6 of the zero-extended result is carry or borrow,
  // shifts put the bit that falls off into bit 6 directly
  always_comb begin
    arith_res = '0;
    case (op_sel)
      OpAdd:   arith_res = a_ext + b_ext;
      OpSub:   arith_res = a_ext - b_ext;
      OpInc:   arith_res = a_ext + 7'd1;
      OpDec:   arith_res = a_ext - 7'd1;
      OpRsb:   arith_res = b_ext - a_ext;
      OpNeg:   arith_res = 7'd0 - a_ext;
      OpShl:   arith_res = {A, 1'b0};
      OpShr:   arith_res = {A[0], 1'b0, A[5:1]};
      default: arith_res = '0;
    endcase
  end

  // Select between units and derive the zero flag from the value being registered
  always_comb begin
    o_d     = '0;
    carry_d = 1'b0;
    if (modo) begin
      o_d     = logic_res;
      carry_d = 1'b0;
    end else begin
      o_d     = arith_res[5:0];
      carry_d = arith_res[6];
    end
    zero_d = (o_d == 6'd0);
  end

  // Output registers; synchronous reset takes priority over any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      o_q     <= 6'd0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      o_q     <= o_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign O         = o_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_ula.sv
// Self-checking bench for ula: expected results are queued when stimulus is driven
// and popped for comparison one edge later.
module tb_ula;

  logic       clk;
  logic       reset;
  logic [5:0] A;
  logic [5:0] B;
  logic       modo;
  logic [2:0] op_sel;
  logic [5:0] O;
  logic       carry_out;
  logic       zero;

  typedef struct {
    logic [5:0] o;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  ula dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .modo      (modo),
    .op_sel    (op_sel),
    .O         (O),
    .carry_out (carry_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written with integer arithmetic
  function automatic exp_t model(input logic rst, input logic [5:0] a, input logic [5:0] b,
                                 input logic m, input logic [2:0] op);
    exp_t r;
    int   ia;
    int   ib;
    int   v;
    logic [5:0] lv;
    ia = int'(a);
    ib = int'(b);
    v  = 0;
    r.c = 1'b0;
    if (rst) begin
      r.o = 6'd0;
      r.c = 1'b0;
      r.z = 1'b1;
      return r;
    end
    if (m) begin
      case (op)
        3'd0: lv = a & b;
        3'd1: lv = a | b;
        3'd2: lv = a ^ b;
        3'd3: lv = ~a;
        3'd4: lv = ~(a & b);
        3'd5: lv = ~(a | b);
        3'd6: lv = ~(a ^ b);
        default: lv = a;
      endcase
      r.o = lv;
    end else begin
      case (op)
        3'd0: begin v = ia + ib; r.c = (v > 63); end
        3'd1: begin v = ia - ib; r.c = (ia < ib); end
        3'd2: begin v = ia + 1;  r.c = (ia == 63); end
        3'd3: begin v = ia - 1;  r.c = (ia == 0); end
        3'd4: begin v = ib - ia; r.c = (ib < ia); end
        3'd5: begin v = -ia;     r.c = (ia != 0); end
        3'd6: begin v = ia * 2;  r.c = (ia >= 32); end
        default: begin v = ia / 2; r.c = (ia % 2 == 1); end
      endcase
      v   = ((v % 64) + 64) % 64;
      r.o = v[5:0];
    end
    r.z = (r.o == 6'd0);
    return r;
  endfunction

  // Drive one operation before the edge, queue its expectation, settle after the edge
  task automatic apply(input logic r, input logic [5:0] a, input logic [5:0] b,
                       input logic m, input logic [2:0] op);
    @(negedge clk);
    reset  = r;
    A      = a;
    B      = b;
    modo   = m;
    op_sel = op;
    sb.push_back(model(r, a, b, m, op));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 6'd21, 6'd0, 1'b1, 3'd7);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {e.o, e.c, e.z}) begin
      bad++;
      $display("FAIL pre_reset: got O=%b c=%b z=%b want O=%b c=%b z=%b",
               O, carry_out, zero, e.o, e.c, e.z);
    end
    apply(1'b1, 6'h3F, 6'h3F, 1'b0, 3'd0);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_values: got O=%b c=%b z=%b want O=000000 c=0 z=1",
               O, carry_out, zero);
    end
    // Deassert reset with a new operation; outputs must hold until the next edge
    @(negedge clk);
    reset  = 1'b0;
    A      = 6'd9;
    B      = 6'd4;
    modo   = 1'b0;
    op_sel = 3'd0;
    sb.push_back(model(1'b0, 6'd9, 6'd4, 1'b0, 3'd0));
    #1;
    total++;
    if ({O, carry_out, zero} !== {e.o, e.c, e.z}) begin
      bad++;
      $display("FAIL reset_hold: got O=%b c=%b z=%b want O=%b c=%b z=%b",
               O, carry_out, zero, e.o, e.c, e.z);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {e.o, e.c, e.z} || O !== 6'd13) begin
      bad++;
      $display("FAIL post_reset_op: got O=%b c=%b z=%b want O=%b c=%b z=%b",
               O, carry_out, zero, e.o, e.c, e.z);
    end
  endtask

  task automatic test_logic();
    logic [5:0] a;
    logic [5:0] b;
    // Directed vectors with hand-derived results
    apply(1'b0, 6'b000000, 6'b111111, 1'b1, 3'b000);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'b000000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL logic_and: got O=%b c=%b z=%b want O=000000 c=0 z=1", O, carry_out, zero);
    end
    apply(1'b0, 6'b000000, 6'b111111, 1'b1, 3'b001);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'b111111, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL logic_or: got O=%b c=%b z=%b want O=111111 c=0 z=0", O, carry_out, zero);
    end
    apply(1'b0, 6'b000000, 6'b111111, 1'b1, 3'b010);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'b111111, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL logic_xor: got O=%b c=%b z=%b want O=111111 c=0 z=0", O, carry_out, zero);
    end
    apply(1'b0, 6'b111111, 6'b000000, 1'b1, 3'b011);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'b000000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL logic_not: got O=%b c=%b z=%b want O=000000 c=0 z=1", O, carry_out, zero);
    end
    apply(1'b0, 6'b101010, 6'b010101, 1'b1, 3'b111);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'b101010, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL logic_pass: got O=%b c=%b z=%b want O=101010 c=0 z=0", O, carry_out, zero);
    end
    // Every logic op over random operands against the model
    for (int i = 0; i < 3; i++) begin
      a = 6'($urandom);
      b = 6'($urandom);
      for (int op = 0; op < 8; op++) begin
        apply(1'b0, a, b, 1'b1, 3'(op));
        e = sb.pop_front();
        total++;
        if ({O, carry_out, zero} !== {e.o, e.c, e.z}) begin
          bad++;
          $display("FAIL logic_op%0d a=%b b=%b: got O=%b c=%b z=%b want O=%b c=%b z=%b",
                   op, a, b, O, carry_out, zero, e.o, e.c, e.z);
        end
      end
    end
  endtask

  task automatic test_arith();
    logic [5:0] av[12];
    logic [5:0] bv[12];
    logic [2:0] ov[12];
    logic [5:0] wo[12];
    logic       wc[12];
    // Directed vectors and wrap boundaries: {A, B, op, expected O, expected carry}
    av = '{6'h3F, 6'd3, 6'd5, 6'd7, 6'h3F, 6'd0, 6'd0,  6'd1,  6'd5, 6'd9, 6'd0, 6'd0};
    bv = '{6'd1,  6'd4, 6'd7, 6'd5, 6'd0,  6'd0, 6'd0,  6'd0,  6'd2, 6'd9, 6'd0, 6'h3F};
    ov = '{3'd0,  3'd0, 3'd1, 3'd1, 3'd2,  3'd3, 3'd5,  3'd5,  3'd4, 3'd4, 3'd2, 3'd4};
    wo = '{6'd0,  6'd7, 6'h3E, 6'd2, 6'd0, 6'h3F, 6'd0, 6'h3F, 6'h3D, 6'd0, 6'd1, 6'h3F};
    wc = '{1'b1,  1'b0, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0,  1'b1,  1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, av[i], bv[i], 1'b0, ov[i]);
      e = sb.pop_front();
      total++;
      if ({O, carry_out, zero} !== {wo[i], wc[i], (wo[i] == 6'd0)}) begin
        bad++;
        $display("FAIL arith_vec%0d op=%0d: got O=%b c=%b z=%b want O=%b c=%b z=%b",
                 i, ov[i], O, carry_out, zero, wo[i], wc[i], (wo[i] == 6'd0));
      end
    end
  endtask

  task automatic test_shift();
    apply(1'b0, 6'b100001, 6'd0, 1'b0, 3'b110);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'b000010, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL shl: got O=%b c=%b z=%b want O=000010 c=1 z=0", O, carry_out, zero);
    end
    apply(1'b0, 6'b000011, 6'd0, 1'b0, 3'b111);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'b000001, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL shr: got O=%b c=%b z=%b want O=000001 c=1 z=0", O, carry_out, zero);
    end
    apply(1'b0, 6'b000001, 6'd0, 1'b0, 3'b111);
    e = sb.pop_front();
    total++;
    if ({O, carry_out, zero} !== {6'b000000, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL shr_to_zero: got O=%b c=%b z=%b want O=000000 c=1 z=1", O, carry_out, zero);
    end
  endtask

  // Random mode/op every cycle with a one-cycle reset pulse in the middle
  task automatic test_back_to_back();
    logic       r;
    logic [5:0] a;
    logic [5:0] b;
    logic       m;
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      r  = (i == 30);
      a  = 6'($urandom);
      b  = 6'($urandom);
      m  = 1'($urandom);
      op = 3'($urandom);
      apply(r, a, b, m, op);
      e = sb.pop_front();
      total++;
      if ({O, carry_out, zero} !== {e.o, e.c, e.z}) begin
        bad++;
        $display("FAIL b2b%0d r=%b m=%b op=%0d a=%b b=%b: got O=%b c=%b z=%b want O=%b c=%b z=%b",
                 i, r, m, op, a, b, O, carry_out, zero, e.o, e.c, e.z);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    A      = 6'd0;
    B      = 6'd0;
    modo   = 1'b0;
    op_sel = 3'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_logic();
    test_arith();
    test_shift();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
